// File: rtl/cpu_debug_jtag_host.sv
// Host-side virtual-JTAG initiator: one IR+DR command in, UIR/CDR/SDR/UDR/RTI sequence out, scan-out returned.
// Optional IR cache (skip UIR when the IR is unchanged) is enabled by defining CPU_DEBUG_JTAG_HOST_IR_CACHE_EN.
module cpu_debug_jtag_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RTI  = 3'd5,
    RESP = 3'd6
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                tck_nxt;
  logic [BW-1:0]       bit_cnt, bit_nxt;
  logic [DR_WIDTH-1:0] shift, shift_nxt;
  logic                held_tdo, held_nxt;
  logic [IR_WIDTH-1:0] ir_nxt;
  logic [DR_WIDTH-1:0] rsp_dr_nxt;
  logic                rsp_valid_nxt;
  logic                active, tck_rise, period_end, skip_uir;

  assign active     = (state == UIR) || (state == CDR) || (state == SDR) ||
                      (state == UDR) || (state == RTI);
  assign tck_rise   = active && !vji_tck && (cnt == CNT_LAST);
  assign period_end = active &&  vji_tck && (cnt == CNT_LAST);

`ifdef CPU_DEBUG_JTAG_HOST_IR_CACHE_EN
  logic ir_valid;

  // vji_ir_in holds the IR of the last completed transaction; ir_valid says whether it can be trusted
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_valid <= 1'b0;
    end else if ((state == RTI) && period_end) begin
      ir_valid <= 1'b1;
    end else begin
      ir_valid <= ir_valid;
    end
  end

  assign skip_uir = ir_valid && (cmd_ir == vji_ir_in);
`else
  assign skip_uir = 1'b0;
`endif

  // Next-state, tck divider, shift register and response datapath
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    tck_nxt       = vji_tck;
    bit_nxt       = bit_cnt;
    shift_nxt     = shift;
    held_nxt      = held_tdo;
    ir_nxt        = vji_ir_in;
    rsp_dr_nxt    = rsp_dr;
    rsp_valid_nxt = rsp_valid;

    if (active) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        tck_nxt = ~vji_tck;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end else begin
      cnt_nxt = '0;
      tck_nxt = 1'b0;
    end

    if (tck_rise && (state == SDR)) begin
      held_nxt = vji_tdo;
    end else begin
      held_nxt = held_tdo;
    end

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ir_nxt    = cmd_ir;
          shift_nxt = cmd_dr;
          bit_nxt   = '0;
          state_nxt = skip_uir ? CDR : UIR;
        end else begin
          state_nxt = IDLE;
        end
      end
      UIR: begin
        if (period_end) state_nxt = CDR;
        else            state_nxt = UIR;
      end
      CDR: begin
        if (period_end) state_nxt = SDR;
        else            state_nxt = CDR;
      end
      SDR: begin
        if (period_end) begin
          shift_nxt = {held_tdo, shift[DR_WIDTH-1:1]};
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = UDR;
          end else begin
            bit_nxt   = bit_cnt + BW'(1);
          end
        end else begin
          state_nxt = SDR;
        end
      end
      UDR: begin
        if (period_end) state_nxt = RTI;
        else            state_nxt = UDR;
      end
      RTI: begin
        if (period_end) begin
          rsp_dr_nxt    = shift;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else begin
          state_nxt     = RTI;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          state_nxt     = RESP;
        end
      end
      default: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; strobes and tdi are registered from next-state so they align with state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      held_tdo  <= 1'b0;
      vji_tck   <= 1'b0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
      rsp_dr    <= '0;
      rsp_valid <= 1'b0;
      cmd_ready <= 1'b1;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_nxt;
      shift     <= shift_nxt;
      held_tdo  <= held_nxt;
      vji_tck   <= tck_nxt;
      vji_tdi   <= (state_nxt == SDR) ? shift_nxt[0] : 1'b0;
      vji_ir_in <= ir_nxt;
      rsp_dr    <= rsp_dr_nxt;
      rsp_valid <= rsp_valid_nxt;
      cmd_ready <= (state_nxt == IDLE);
      vji_uir   <= (state_nxt == UIR);
      vji_cdr   <= (state_nxt == CDR);
      vji_sdr   <= (state_nxt == SDR);
      vji_udr   <= (state_nxt == UDR);
      vji_rti   <= (state_nxt == RTI);
    end
  end

endmodule

// File: tb/tb_cpu_debug_jtag_host.sv
// Scoreboard bench for cpu_debug_jtag_host (TCK_DIV=2 main instance, TCK_DIV=1 second instance).
// Tracks CPU_DEBUG_JTAG_HOST_IR_CACHE_EN to predict UIR skipping.
module tb_cpu_debug_jtag_host;
  localparam int DRW = 38;
  localparam int IRW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int edges  = 0;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // ---------------- main DUT (TCK_DIV=2) ----------------
  logic reset = 1'b1, cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b1;
  logic [IRW-1:0] cmd_ir = '0, vji_ir_in;
  logic [DRW-1:0] cmd_dr = '0, rsp_dr;
  logic vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic tdo_loop = 1'b0, tdo_const = 1'b1;
  assign vji_tdo = tdo_loop ? vji_tdi : tdo_const;

  cpu_debug_jtag_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti));

  // ---------------- second DUT (TCK_DIV=1, loopback) ----------------
  logic cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1;
  logic [IRW-1:0] cmd_ir1 = '0, vji_ir_in1;
  logic [DRW-1:0] cmd_dr1 = '0, rsp_dr1;
  logic vji_tck1, vji_tdi1, vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;

  cpu_debug_jtag_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1), .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
    .rsp_dr(rsp_dr1), .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdi1),
    .vji_ir_in(vji_ir_in1), .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1),
    .vji_udr(vji_udr1), .vji_rti(vji_rti1));

  typedef struct {
    logic [DRW-1:0] dr;
    logic [IRW-1:0] ir;
    int             acc;
    int             delta;
    logic [29:0]    sig;
    int             scyc;
    logic           loop;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // ---------------- strobe / tdi logger for main DUT ----------------
  logic        log_clr = 1'b0;
  logic [4:0]  code, prev_code = 5'd0;
  logic        prev_tck = 1'b0, prev_tdi = 1'b0;
  logic [29:0] order_sig = 30'd0;
  logic [DRW-1:0] tdi_cap = '0;
  logic [IRW-1:0] ir_cdr = '0;
  int n_rise = 0, n_strobe = 0, n_sdr = 0, viol = 0;
  assign code = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};

  always @(negedge clk) begin
    prev_code <= code;
    prev_tck  <= vji_tck;
    prev_tdi  <= vji_tdi;
    if (log_clr) begin
      order_sig <= 30'd0; tdi_cap <= '0; n_rise <= 0; n_strobe <= 0; n_sdr <= 0; viol <= 0;
    end else begin
      if (code != 5'd0 && code != prev_code) order_sig <= {order_sig[24:0], code};
      if (code != 5'd0) n_strobe <= n_strobe + 1;
      if (vji_sdr) n_sdr <= n_sdr + 1;
      if (vji_cdr) ir_cdr <= vji_ir_in;
      if (($countones(code) > 1) || (vji_tck && !prev_tck && vji_tdi != prev_tdi)) viol <= viol + 1;
      if (vji_tck && !prev_tck && vji_sdr) begin
        tdi_cap <= {vji_tdi, tdi_cap[DRW-1:1]};
        n_rise  <= n_rise + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard for main DUT ----------------
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    prev_rv <= rsp_valid;
    if (rsp_valid && !prev_rv) begin
      if (q0.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("rsp_dr", 64'(rsp_dr), 64'(e.dr));
        chk("latency", 64'(edges - e.acc), 64'(e.delta));
        chk("strobe_order", 64'(order_sig), 64'(e.sig));
        chk("strobe_cycles", 64'(n_strobe), 64'(e.scyc));
        chk("sdr_cycles", 64'(n_sdr), 64'(DRW * 4));
        chk("ir_in", 64'(ir_cdr), 64'(e.ir));
        chk("tdi_timing", 64'(viol), 64'd0);
        if (e.loop) chk("tdi_seq", 64'(tdi_cap), 64'(e.dr));
      end
    end
  end

  // ---------------- logger / monitor for TCK_DIV=1 DUT ----------------
  logic prev_tck1 = 1'b0, prev_sdr1 = 1'b0, prev_rv1 = 1'b0;
  int   hold1 = 0;
  always @(negedge clk) begin
    prev_tck1 <= vji_tck1;
    prev_sdr1 <= vji_sdr1;
    prev_rv1  <= rsp_valid1;
    if (vji_sdr1 && prev_sdr1 && vji_tck1 == prev_tck1) hold1 <= hold1 + 1;
    if (rsp_valid1 && !prev_rv1) begin
      if (q1.size() == 0) begin
        chk("unexpected_rsp1", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("rsp_dr1", 64'(rsp_dr1), 64'(e.dr));
        chk("latency1", 64'(edges - e.acc), 64'(e.delta));
        chk("tck1_toggle", 64'(hold1), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic           model_valid = 1'b0;
  logic [IRW-1:0] model_ir = '0;

  task automatic issue(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                       input logic [DRW-1:0] exp_dr, input logic loop, input logic tie,
                       input logic push);
    exp_t e;
    int   g = 0;
    logic skip;
    while (!cmd_ready && g < 2000) begin @(posedge clk); #1; g++; end
    chk("ready_before_issue", 64'(cmd_ready), 64'd1);
`ifdef CPU_DEBUG_JTAG_HOST_IR_CACHE_EN
    skip = model_valid && (model_ir == ir);
`else
    skip = 1'b0;
`endif
    e.dr    = exp_dr;
    e.ir    = ir;
    e.acc   = edges + 1;
    e.delta = (DRW + 4 - (skip ? 1 : 0)) * 2 * 2;
    e.sig   = skip ? 30'({5'b01000, 5'b00100, 5'b00010, 5'b00001})
                   : 30'({5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001});
    e.scyc  = (DRW + 4 - (skip ? 1 : 0)) * 4;
    e.loop  = loop;
    if (push) q0.push_back(e);
    tdo_loop = loop; tdo_const = tie;
    log_clr = 1'b1; cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
    @(negedge clk); #1 log_clr = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0; cmd_ir = ~ir; cmd_dr = ~dr;
    if (push) begin model_valid = 1'b1; model_ir = ir; end
  endtask

  task automatic wait_done();
    int g = 0;
    while ((q0.size() != 0 || !cmd_ready) && g < 3000) begin @(posedge clk); #1; g++; end
    chk("rsp_pending", 64'(q0.size()), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int bad_v, bad_d, bad_r;
    exp_t e1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_ready", 64'(cmd_ready), 64'd1);
    chk("reset_rsp", 64'({rsp_valid, rsp_dr}), 64'd0);
    chk("reset_jtag", 64'({vji_tck, vji_tdi, vji_ir_in}), 64'd0);
    chk("reset_strobes", 64'(code), 64'd0);

    // tdo tied high, all-zero data in
    issue(2'b01, 38'h0, 38'h3F_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    wait_done();
    // loopback preserves data, tdi LSB first
    issue(2'b01, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A, 1'b1, 1'b0, 1'b1);
    wait_done();

    // response held off for 20 cycles while a second command is offered
    rsp_ready = 1'b0;
    issue(2'b10, 38'h12_3456_789A, 38'h12_3456_789A, 1'b1, 1'b0, 1'b1);
    g = 0;
    while (!rsp_valid && g < 2000) begin @(posedge clk); #1; g++; end
    chk("rsp_arrives", 64'(rsp_valid), 64'd1);
    cmd_valid = 1'b1; cmd_ir = 2'b00; cmd_dr = 38'h3F_0F0F_0F0F;
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid) bad_v++;
      if (rsp_dr != 38'h12_3456_789A) bad_d++;
      if (cmd_ready) bad_r++;
    end
    chk("hold_rsp_valid", 64'(bad_v), 64'd0);
    chk("hold_rsp_dr", 64'(bad_d), 64'd0);
    chk("hold_cmd_ready", 64'(bad_r), 64'd0);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rsp", 64'({cmd_ready, rsp_valid}), 64'b10);

    // repeated IR, then a new IR
    issue(2'b10, 38'h01_0203_0405, 38'h01_0203_0405, 1'b1, 1'b0, 1'b1);
    wait_done();
    issue(2'b11, 38'h3C_3C3C_3C3C, 38'h0, 1'b0, 1'b0, 1'b1);
    wait_done();

    // reset during SDR bit 10 discards the transaction
    issue(2'b01, 38'h15_5555_5555, 38'h0, 1'b1, 1'b0, 1'b0);
    g = 0;
    while (n_rise < 11 && g < 2000) begin @(posedge clk); #1; g++; end
    chk("reached_bit10", 64'(n_rise), 64'd11);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_valid = 1'b0;
    chk("midreset_tck_sdr", 64'({vji_tck, vji_sdr}), 64'd0);
    chk("midreset_ready", 64'({cmd_ready, rsp_valid}), 64'b10);
    repeat (400) @(posedge clk);
    #1 chk("midreset_no_rsp", 64'(rsp_valid), 64'd0);

    // recovery after reset (cache cleared, so UIR expected again)
    issue(2'b11, 38'h3F_0000_00FF, 38'h3F_0000_00FF, 1'b1, 1'b0, 1'b1);
    wait_done();

    // TCK_DIV=1 instance: latency 84 edges after accept
    e1.dr = 38'h15_A5A5_A5A5; e1.ir = 2'b01; e1.acc = edges + 1;
    e1.delta = (DRW + 4) * 2; e1.sig = 30'd0; e1.scyc = 0; e1.loop = 1'b1;
    q1.push_back(e1);
    cmd_valid1 = 1'b1; cmd_ir1 = 2'b01; cmd_dr1 = 38'h15_A5A5_A5A5;
    @(posedge clk); #1 cmd_valid1 = 1'b0; cmd_dr1 = '0;
    g = 0;
    while (q1.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
    chk("rsp1_pending", 64'(q1.size()), 64'd0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
